load_store_unit: RTL and testbench
==================================

# load_store_unit

Multicycle memory-stage engine for the Philosophy-V core. It sits directly downstream of the execute register and takes the ALU-computed effective address plus store data from it. It runs one load or store against data memory over a request/acknowledge handshake with arbitrary wait states, and returns lane-aligned, sign- or zero-extended load data to writeback. The main controller starts it with a one-cycle pulse and waits on `done`.

## Interface
- `N`, 32, data and address bus width; must be 32.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle request pulse from the controller; ignored while `busy`=1.
- `isStore`  in  1  1 = store, 0 = load; sampled with `start`.
- `funct3`  in  3  RV32I width/sign code: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
- `addr`  in  N  effective byte address from the execute register.
- `storeData`  in  N  rs2 value; low byte/half used for SB/SH.
- `busy`  out  1  high from the cycle after `start` until the `done` cycle inclusive.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  valid with `done`: illegal funct3, or misaligned access when checking is compiled in.
- `loadData`  out  N  extended load result; holds until the next successful load.
- `memReq`  out  1  request to data memory; held until `memAck`.
- `memWe`  out  1  write strobe, valid with `memReq`.
- `memAddr`  out  N  word address, `{addr[N-1:2],2'b00}`.
- `memWrData`  out  N  lane-replicated store data.
- `memByteEn`  out  4  byte enables, valid with `memReq`.
- `memRdData`  in  N  read word; valid in the `memAck` cycle.
- `memAck`  in  1  completion from memory; counts only while `memReq`=1.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE.** On `start`, latch `isStore`, `funct3`, `addr` and `storeData`.
  - Illegal funct3 goes to DONE with `error`=1 and no memory request. Illegal codes are 011, 110, 111 for loads and anything above 010 for stores.
  - A misaligned access also goes to DONE with `error`=1 when `PHILV_MISALIGN_CHECK_EN` is defined (see Configuration).
  - Otherwise go to ACCESS.
- **ACCESS.** `memReq`=1, and `memWe`=`isStore`. Address, data and byte-enable outputs stay stable until ack. On `memAck`, a load captures the formatted `memRdData` into `loadData`; then go to DONE.
- **DONE.** `done`=1 for one cycle, then IDLE.
- Store formatting:
  - SB: byte replicated ×4; `memByteEn` = 1<<addr[1:0].
  - SH: half replicated ×2; `memByteEn` = 0011 if addr[1]=0, else 1100.
  - SW: `memByteEn` = 1111.
- Load formatting: select the byte lane addr[1:0] or half lane addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Loads drive `memByteEn` = 1111.
- Errored operations leave `loadData` unchanged.

## Timing
- Reset values: state IDLE; `busy`, `done`, `error`, `memReq`, `memWe` = 0; `loadData`, `memAddr`, `memWrData` = 0; `memByteEn` = 0000.
- Latency, with `start` at cycle T:
  - `memReq` rises at T+1.
  - With `memAck` at T+1, `done` and `loadData` are valid at T+2. Minimum is 2 cycles start-to-done.
  - Each wait cycle adds 1.
- Error path: `done` at T+1; `memReq` never asserts.
- `memAck` while `memReq`=0 is ignored.
- `start` during `busy` is dropped; no queueing.
- `rst` mid-ACCESS: `memReq` is low on the next edge and the in-flight access is abandoned. The memory must tolerate a dropped request.
- `rst` and `start` in the same cycle: reset wins.

## Configuration
- `PHILV_MISALIGN_CHECK_EN` defined:
  - LH/LHU/SH with addr[0]=1 end with `error`=1 and no request.
  - LW/SW with addr[1:0]≠00 end with `error`=1 and no request.
- Undefined: no alignment check. Halfword lane select uses addr[1]; word accesses ignore addr[1:0]; `error` is raised only for illegal funct3.

## Structure
- Shared header `lsu_defines.h` holds:
  - funct3 encodings: `LSU_LB` … `LSU_SW`.
  - state encodings: `LSU_ST_IDLE`, `LSU_ST_ACCESS`, `LSU_ST_DONE`, width `LSU_ST_WIDTH`.
- Sub-module `lsu_lane_align`: purely combinational store replication, byte-enable generation and load extraction/extension. Tested standalone.
- FSM and latches stay in `load_store_unit`.

## Test plan
- SB: addr=0x103, storeData=0x000000A5, memAck at T+1 -> `memWrData`=0xA5A5A5A5, `memByteEn`=1000, `memAddr`=0x100, `memWe`=1, `done` at T+2.
- LB then LBU: addr=0x202, memRdData=0x12F03456 -> `loadData`=0xFFFFFFF0, then 0x000000F0.
- LW with memAck after 3 wait cycles -> `memReq` held 4 cycles with stable outputs; `done` at T+5; `loadData`=memRdData.
- With `PHILV_MISALIGN_CHECK_EN`, LW addr=0x101 -> `done`=1 and `error`=1 at T+1, `memReq` never high, `loadData` unchanged. Without the macro -> normal access to 0x100.
- Illegal load funct3=011 -> `error`=1 at T+1. A second `start` pulse at T+1 is ignored.
- `rst` asserted during a wait state -> `memReq`=0, `busy`=0, `done`=0 on the next edge. A new `start` afterwards completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared widths, funct3 and FSM encodings for the load/store unit.
package load_store_unit_pkg;
    localparam int N = 32;
    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;
    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;
    localparam int LSU_ST_WIDTH = 2;
    localparam logic [LSU_ST_WIDTH-1:0] LSU_ST_IDLE   = 2'd0;
    localparam logic [LSU_ST_WIDTH-1:0] LSU_ST_ACCESS = 2'd1;
    localparam logic [LSU_ST_WIDTH-1:0] LSU_ST_DONE   = 2'd2;
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        return is_store ? (f3 > LSU_SW) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: data-memory request/acknowledge bus between the LSU (master) and memory (slave).
interface load_store_unit_if;
    logic                             memReq;
    logic                             memWe;
    logic [load_store_unit_pkg::N-1:0] memAddr;
    logic [load_store_unit_pkg::N-1:0] memWrData;
    logic [3:0]                       memByteEn;
    logic [load_store_unit_pkg::N-1:0] memRdData;
    logic                             memAck;
    modport master (output memReq, memWe, memAddr, memWrData, memByteEn, input memRdData, memAck);
    modport slave  (input memReq, memWe, memAddr, memWrData, memByteEn, output memRdData, memAck);
endinterface

// File: rtl/load_store_unit_lane_align.sv
// load_store_unit_lane_align: combinational store lane replication, byte enables and load extraction/extension.
module load_store_unit_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]   funct3,
    input  logic [1:0]   byte_off,
    input  logic         is_store,
    input  logic [N-1:0] store_data,
    input  logic [N-1:0] rd_data,
    output logic [N-1:0] wr_data,
    output logic [N-1:0] load_data,
    output logic [3:0]   byte_en
);
    logic [7:0]  lb;
    logic [15:0] lh;
    always_comb begin
        lb = rd_data[{byte_off, 3'b000} +: 8];
        lh = byte_off[1] ? rd_data[31:16] : rd_data[15:0];
        wr_data = funct3 == LSU_SB ? {4{store_data[7:0]}} :
                  funct3 == LSU_SH ? {2{store_data[15:0]}} : store_data;
        byte_en = !is_store          ? 4'b1111 :
                  funct3 == LSU_SB   ? 4'b0001 << byte_off :
                  funct3 == LSU_SH   ? (byte_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        load_data = funct3 == LSU_LB  ? {{24{lb[7]}}, lb} :
                    funct3 == LSU_LH  ? {{16{lh[15]}}, lh} :
                    funct3 == LSU_LBU ? {24'd0, lb} :
                    funct3 == LSU_LHU ? {16'd0, lh} :
                    funct3 == LSU_LW  ? rd_data : rd_data;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multicycle memory-stage FSM (IDLE/ACCESS/DONE) over a req/ack data-memory bus.
// Define PHILV_MISALIGN_CHECK_EN to reject misaligned half/word accesses with error instead of issuing them.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         isStore,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] storeData,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [N-1:0] loadData,
    load_store_unit_if.master mem
);
    logic [LSU_ST_WIDTH-1:0] state;
    logic         is_store_q;
    logic [2:0]   f3_q;
    logic [1:0]   off_q;
    logic         idle;
    logic         misalign;
    logic         bad;
    logic [N-1:0] wr_data;
    logic [N-1:0] ld_data;
    logic [3:0]   byte_en;

`ifdef PHILV_MISALIGN_CHECK_EN
    assign misalign = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign idle       = state == LSU_ST_IDLE;
    assign bad        = f3_illegal(isStore, funct3) || misalign;
    assign busy       = !idle;
    assign done       = state == LSU_ST_DONE;
    assign mem.memReq = state == LSU_ST_ACCESS;

    // Store formatting uses the live inputs at start; load extraction uses the latched op.
    load_store_unit_lane_align u_align (
        .funct3     (idle ? funct3 : f3_q),
        .byte_off   (idle ? addr[1:0] : off_q),
        .is_store   (idle ? isStore : is_store_q),
        .store_data (storeData),
        .rd_data    (mem.memRdData),
        .wr_data    (wr_data),
        .load_data  (ld_data),
        .byte_en    (byte_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= LSU_ST_IDLE;
            error         <= 1'b0;
            loadData      <= '0;
            is_store_q    <= 1'b0;
            f3_q          <= 3'b000;
            off_q         <= 2'b00;
            mem.memWe     <= 1'b0;
            mem.memAddr   <= '0;
            mem.memWrData <= '0;
            mem.memByteEn <= 4'b0000;
        end else if (idle && start) begin
            is_store_q <= isStore;
            f3_q       <= funct3;
            off_q      <= addr[1:0];
            error      <= bad;
            state      <= bad ? LSU_ST_DONE : LSU_ST_ACCESS;
            if (!bad) begin
                mem.memWe     <= isStore;
                mem.memAddr   <= {addr[N-1:2], 2'b00};
                mem.memWrData <= wr_data;
                mem.memByteEn <= byte_en;
            end
        end else if (state == LSU_ST_ACCESS && mem.memAck) begin
            if (!is_store_q)
                loadData <= ld_data;
            mem.memWe <= 1'b0;
            state     <= LSU_ST_DONE;
        end else if (!idle && state != LSU_ST_ACCESS) begin
            state <= LSU_ST_IDLE;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed + random load/store sequences checked against an arithmetic reference model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        isStore = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] storeData = '0;
    logic        busy, done, error;
    logic [31:0] loadData;
    logic [31:0] model_ld = '0;
    int total = 0;
    int bad = 0;

    load_store_unit_if mif ();

    load_store_unit dut (
        .clk(clk), .rst(rst), .start(start), .isStore(isStore), .funct3(funct3),
        .addr(addr), .storeData(storeData), .busy(busy), .done(done), .error(error),
        .loadData(loadData), .mem(mif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bad(input logic st, input logic [2:0] f3, input logic [31:0] a);
        logic ill, mis;
        ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis = 1'b0;
`ifdef PHILV_MISALIGN_CHECK_EN
        mis = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
`endif
        return ill || mis;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'((rd >> (8 * off)) & 32'hFF);
        h = 16'((rd >> (16 * off[1])) & 32'hFFFF);
        case (f3)
            3'd0: return 32'($signed(b));
            3'd1: return 32'($signed(h));
            3'd4: return 32'(b);
            3'd5: return 32'(h);
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] exp_wr(input logic [2:0] f3, input logic [31:0] sd);
        return f3 == 3'd0 ? sd[7:0] * 32'h01010101 : f3 == 3'd1 ? sd[15:0] * 32'h00010001 : sd;
    endfunction

    function automatic logic [3:0] exp_be(input logic st, input logic [2:0] f3, input logic [1:0] off);
        if (!st || f3 == 3'd2) return 4'hF;
        return f3 == 3'd0 ? 4'(1 << off) : 4'(3 << (2 * off[1]));
    endfunction

    // One operation: start pulse, `waits` wait states, then ack; optional second start at T+1.
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int waits, input logic restart);
        logic e;
        e = exp_bad(st, f3, a);
        isStore = st; funct3 = f3; addr = a; storeData = sd; start = 1'b1;
        tick();
        start = 1'b0;
        isStore = $urandom; funct3 = 3'($urandom); addr = $urandom; storeData = $urandom;
        if (e) begin
            chk("err_done", done, 1'b1);
            chk("err_flag", error, 1'b1);
            chk("err_noreq", mif.memReq, 1'b0);
            chk("err_ld_hold", loadData, model_ld);
            if (restart) begin
                isStore = 1'b0; funct3 = 3'd2; addr = 32'h40; start = 1'b1;
            end
            tick();
            start = 1'b0;
        end else begin
            for (int i = 0; i <= waits; i++) begin
                chk("req", mif.memReq, 1'b1);
                chk("busy", busy, 1'b1);
                chk("no_done", done, 1'b0);
                chk("we", mif.memWe, st);
                chk("maddr", mif.memAddr, {a[31:2], 2'b00});
                chk("be", 32'(mif.memByteEn), 32'(exp_be(st, f3, a[1:0])));
                if (st) chk("wdata", mif.memWrData, exp_wr(f3, sd));
                mif.memRdData = (i == waits) ? rd : $urandom;
                mif.memAck = (i == waits);
                tick();
            end
            mif.memAck = 1'b0;
            if (!st) model_ld = exp_load(f3, a[1:0], rd);
            chk("done", done, 1'b1);
            chk("ok_err", error, 1'b0);
            chk("req_drop", mif.memReq, 1'b0);
            chk("ld", loadData, model_ld);
            tick();
        end
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("idle_req", mif.memReq, 1'b0);
    endtask

    initial begin
        mif.memAck = 1'b0;
        mif.memRdData = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", error, 1'b0);
        chk("rst_req", mif.memReq, 1'b0);
        chk("rst_we", mif.memWe, 1'b0);
        chk("rst_ld", loadData, 32'h0);
        chk("rst_addr", mif.memAddr, 32'h0);
        chk("rst_wd", mif.memWrData, 32'h0);
        chk("rst_be", 32'(mif.memByteEn), 32'h0);
        // Stray ack while idle must do nothing.
        mif.memAck = 1'b1; mif.memRdData = 32'hDEADBEEF;
        tick();
        mif.memAck = 1'b0;
        chk("stray_ack_req", mif.memReq, 1'b0);
        chk("stray_ack_done", done, 1'b0);
        chk("stray_ack_ld", loadData, 32'h0);

        do_op(1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, 1'b0);
        chk("sb_wd", mif.memWrData, 32'hA5A5A5A5);
        chk("sb_be", 32'(mif.memByteEn), 32'h8);
        do_op(1'b0, 3'd0, 32'h202, 32'h0, 32'h12F03456, 0, 1'b0);
        chk("lb_spec", loadData, 32'hFFFFFFF0);
        do_op(1'b0, 3'd4, 32'h202, 32'h0, 32'h12F03456, 1, 1'b0);
        chk("lbu_spec", loadData, 32'h000000F0);
        do_op(1'b0, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, 3, 1'b0);
        chk("lw_spec", loadData, 32'hCAFEF00D);
        do_op(1'b1, 3'd1, 32'h406, 32'h0000BEEF, 32'h0, 2, 1'b0);
        chk("sh_be", 32'(mif.memByteEn), 32'hC);
        do_op(1'b0, 3'd1, 32'h502, 32'h0, 32'h8001_7FFF, 0, 1'b0);
        chk("lh_spec", loadData, 32'hFFFF8001);
        do_op(1'b0, 3'd2, 32'h101, 32'h0, 32'h55AA55AA, 0, 1'b0);
        do_op(1'b0, 3'd3, 32'h600, 32'h0, 32'h0, 0, 1'b1);
        do_op(1'b1, 3'd5, 32'h600, 32'h1234, 32'h0, 0, 1'b0);
        chk("ld_after_err", loadData, model_ld);

        // Reset during a wait state abandons the access.
        isStore = 1'b0; funct3 = 3'd2; addr = 32'h700; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_req", mif.memReq, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        // Reset and start together: reset wins.
        start = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b0;
        chk("rst_start_busy", busy, 1'b0);
        model_ld = '0;
        chk("rst_ld_clear", loadData, 32'h0);
        do_op(1'b0, 3'd5, 32'h702, 32'h0, 32'hA1B2C3D4, 1, 1'b0);

        for (int k = 0; k < 80; k++)
            do_op(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 3), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
